// File: rtl/wb_sequencer.sv
// Write-back sequencer: one-shot SP init after reset, then sequences
// memToReg selector / reg_write / write_reg for ALU and load write-backs,
// inserting MEM_WAIT memory wait states ahead of load writes.
module wb_sequencer #(
  parameter int unsigned MEM_WAIT = 2,
  parameter int unsigned SP_REG   = 29
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_src,
  input  logic       req_is_load,
  input  logic [4:0] req_dst,
  output logic       mem_rd,
  output logic [3:0] sel,
  output logic       reg_write,
  output logic [4:0] write_reg,
  output logic       init_done,
  output logic       busy
);

  localparam int unsigned SRC_W = 3;
  localparam int unsigned REG_W = 5;
  localparam int unsigned SEL_W = 4;
  localparam int unsigned CNT_W = 4;

  localparam bit               HAS_WAIT  = (MEM_WAIT != 0);
  localparam logic [CNT_W-1:0] CNT_INIT  = HAS_WAIT ? CNT_W'(MEM_WAIT - 1) : '0;
  localparam logic [REG_W-1:0] SP_IDX    = REG_W'(SP_REG);
  localparam logic [SEL_W-1:0] SEL_CONST = 4'b1000;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_IDLE  = 2'd1,
    S_WAIT  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [SRC_W-1:0]   src_q;
  logic [REG_W-1:0]   dst_q;
  logic [CNT_W-1:0]   cnt;
  logic               init_q;
  logic               accept;

  assign accept = (state == S_IDLE) && req_valid;

  // State register; reset restarts at INIT so SP is re-initialised
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_INIT;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      S_INIT:  state_nx = S_IDLE;
      S_IDLE: begin
        if (req_valid) begin
          state_nx = (req_is_load && HAS_WAIT) ? S_WAIT : S_WRITE;
        end
      end
      S_WAIT:  if (cnt == '0) state_nx = S_WRITE;
      S_WRITE: state_nx = S_IDLE;
      default: state_nx = S_INIT;
    endcase
  end

  // Latched request fields, wait counter and sticky init flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_q  <= '0;
      dst_q  <= '0;
      cnt    <= '0;
      init_q <= 1'b0;
    end else begin
      if (accept) begin
        src_q <= req_src;
        dst_q <= req_dst;
        if (req_is_load && HAS_WAIT) begin
          cnt <= CNT_INIT;
        end
      end else if ((state == S_WAIT) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
      if (state == S_INIT) begin
        init_q <= 1'b1;
      end
    end
  end

  // Output decode from registered state; everything forced low while in reset
  always_comb begin
    req_ready = 1'b0;
    mem_rd    = 1'b0;
    sel       = '0;
    reg_write = 1'b0;
    write_reg = '0;
    busy      = 1'b0;
    init_done = init_q;
    case (state)
      S_INIT: begin
        sel       = SEL_CONST;
        write_reg = SP_IDX;
        reg_write = 1'b1;
        busy      = 1'b1;
      end
      S_IDLE: begin
        req_ready = 1'b1;
      end
      S_WAIT: begin
        mem_rd    = 1'b1;
        sel       = {1'b0, src_q};
        write_reg = dst_q;
        busy      = 1'b1;
      end
      S_WRITE: begin
        sel       = {1'b0, src_q};
        write_reg = dst_q;
        reg_write = (dst_q != '0);
        busy      = 1'b1;
      end
      default: ;
    endcase
    if (!reset) begin
      req_ready = 1'b0;
      mem_rd    = 1'b0;
      sel       = '0;
      reg_write = 1'b0;
      write_reg = '0;
      busy      = 1'b0;
      init_done = 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_sequencer.sv
// Bench for wb_sequencer: inline per-scenario checks plus a write scoreboard.
module tb_wb_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic [2:0] req_src;
  logic       req_is_load;
  logic [4:0] req_dst;

  logic       req_ready, mem_rd, reg_write, init_done, busy;
  logic [3:0] sel;
  logic [4:0] write_reg;

  logic       req_ready0, mem_rd0, reg_write0, init_done0, busy0;
  logic [3:0] sel0;
  logic [4:0] write_reg0;

  typedef struct packed {
    logic [3:0] sel;
    logic [4:0] wr;
    logic       we;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // Full observation {sel, write_reg, reg_write, mem_rd, req_ready, busy, init_done}
  logic [13:0] obs, obs0;
  // Observation without write_reg (used in IDLE, where the index is don't-care)
  logic [8:0]  obs_nw, obs0_nw;
  assign obs     = {sel, write_reg, reg_write, mem_rd, req_ready, busy, init_done};
  assign obs0    = {sel0, write_reg0, reg_write0, mem_rd0, req_ready0, busy0, init_done0};
  assign obs_nw  = {sel, reg_write, mem_rd, req_ready, busy, init_done};
  assign obs0_nw = {sel0, reg_write0, mem_rd0, req_ready0, busy0, init_done0};

  localparam logic [13:0] OBS_INIT = {4'h8, 5'd29, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [8:0]  OBS_IDLE = {4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  localparam exp_t        EXP_INIT = '{sel: 4'h8, wr: 5'd29, we: 1'b1};

  wb_sequencer #(.MEM_WAIT(2), .SP_REG(29)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_src(req_src), .req_is_load(req_is_load), .req_dst(req_dst),
    .mem_rd(mem_rd), .sel(sel), .reg_write(reg_write), .write_reg(write_reg),
    .init_done(init_done), .busy(busy)
  );

  wb_sequencer #(.MEM_WAIT(0), .SP_REG(29)) dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready0),
    .req_src(req_src), .req_is_load(req_is_load), .req_dst(req_dst),
    .mem_rd(mem_rd0), .sel(sel0), .reg_write(reg_write0), .write_reg(write_reg0),
    .init_done(init_done0), .busy(busy0)
  );

  always #5 clk = ~clk;

  // Scoreboard: every INIT/WRITE cycle of the MEM_WAIT=2 instance must match the next expected write
  always @(negedge clk) begin
    exp_t e;
    if (reset && busy && !mem_rd) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected_write got sel=%0h wr=%0d we=%0b want none", sel, write_reg, reg_write);
      end else begin
        e = q.pop_front();
        if ({sel, write_reg, reg_write} !== e) begin
          fails++;
          $display("FAIL sb_write got sel=%0h wr=%0d we=%0b want sel=%0h wr=%0d we=%0b",
                   sel, write_reg, reg_write, e.sel, e.wr, e.we);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input logic [2:0] src, input logic [4:0] dst, input logic ld);
    req_valid   = 1'b1;
    req_src     = src;
    req_dst     = dst;
    req_is_load = ld;
  endtask

  task automatic test_reset();
    repeat (3) begin
      step();
      tests++;
      if (obs !== 14'd0) begin
        fails++;
        $display("FAIL reset_outputs got %h want 0", obs);
      end
    end
    @(posedge clk);
    #1;
    q.push_back(EXP_INIT);
    reset = 1'b1;
    step();
    tests++;
    if (obs !== OBS_INIT) begin
      fails++;
      $display("FAIL reset_init got %h want %h", obs, OBS_INIT);
    end
    step();
    tests++;
    if (obs_nw !== OBS_IDLE) begin
      fails++;
      $display("FAIL reset_idle got %h want %h", obs_nw, OBS_IDLE);
    end
  endtask

  task automatic test_alu();
    drive(3'd3, 5'd8, 1'b0);
    q.push_back('{sel: 4'h3, wr: 5'd8, we: 1'b1});
    step();
    req_valid = 1'b0;
    tests++;
    if (obs !== {4'h3, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL alu_write got %h want %h", obs, {4'h3, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
    end
    step();
    tests++;
    if (obs_nw !== OBS_IDLE) begin
      fails++;
      $display("FAIL alu_idle got %h want %h", obs_nw, OBS_IDLE);
    end
  endtask

  task automatic test_load();
    drive(3'd1, 5'd9, 1'b1);
    q.push_back('{sel: 4'h1, wr: 5'd9, we: 1'b1});
    for (int i = 0; i < 2; i++) begin
      step();
      req_valid = 1'b0;
      tests++;
      if (obs !== {4'h1, 5'd9, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1}) begin
        fails++;
        $display("FAIL load_wait%0d got %h want %h", i, obs, {4'h1, 5'd9, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1});
      end
    end
    step();
    tests++;
    if (obs !== {4'h1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL load_write got %h want %h", obs, {4'h1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
    end
    step();
    tests++;
    if (obs_nw !== OBS_IDLE) begin
      fails++;
      $display("FAIL load_idle got %h want %h", obs_nw, OBS_IDLE);
    end
  endtask

  task automatic test_back_to_back();
    drive(3'd5, 5'd0, 1'b0);
    q.push_back('{sel: 4'h5, wr: 5'd0, we: 1'b0});
    step();
    tests++;
    if (obs !== {4'h5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL b2b_dst0 got %h want %h", obs, {4'h5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
    end
    drive(3'd2, 5'd4, 1'b0);
    q.push_back('{sel: 4'h2, wr: 5'd4, we: 1'b1});
    step();
    tests++;
    if (obs_nw !== OBS_IDLE) begin
      fails++;
      $display("FAIL b2b_ready got %h want %h", obs_nw, OBS_IDLE);
    end
    step();
    req_valid = 1'b0;
    tests++;
    if (obs !== {4'h2, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL b2b_second got %h want %h", obs, {4'h2, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
    end
    step();
  endtask

  task automatic test_busy_ignore();
    drive(3'd6, 5'd12, 1'b1);
    q.push_back('{sel: 4'h6, wr: 5'd12, we: 1'b1});
    for (int i = 0; i < 2; i++) begin
      step();
      drive(3'd7, 5'd13, 1'b0);
      tests++;
      if (obs !== {4'h6, 5'd12, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1}) begin
        fails++;
        $display("FAIL busy_wait%0d got %h want %h", i, obs, {4'h6, 5'd12, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1});
      end
    end
    step();
    req_valid = 1'b0;
    tests++;
    if (obs !== {4'h6, 5'd12, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL busy_write got %h want %h", obs, {4'h6, 5'd12, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
    end
    repeat (2) begin
      step();
      tests++;
      if (obs_nw !== OBS_IDLE) begin
        fails++;
        $display("FAIL busy_idle got %h want %h", obs_nw, OBS_IDLE);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    drive(3'd4, 5'd10, 1'b1);
    step();
    req_valid = 1'b0;
    tests++;
    if (obs !== {4'h4, 5'd10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL abort_wait got %h want %h", obs, {4'h4, 5'd10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1});
    end
    #2 reset = 1'b0;
    #1;
    tests++;
    if (obs !== 14'd0) begin
      fails++;
      $display("FAIL abort_async got %h want 0", obs);
    end
    repeat (2) step();
    @(posedge clk);
    #1;
    q.push_back(EXP_INIT);
    reset = 1'b1;
    step();
    tests++;
    if (obs !== OBS_INIT) begin
      fails++;
      $display("FAIL abort_reinit got %h want %h", obs, OBS_INIT);
    end
    repeat (3) begin
      step();
      tests++;
      if (obs_nw !== OBS_IDLE) begin
        fails++;
        $display("FAIL abort_idle got %h want %h", obs_nw, OBS_IDLE);
      end
    end
  endtask

  task automatic test_zero_wait();
    drive(3'd7, 5'd17, 1'b1);
    q.push_back('{sel: 4'h7, wr: 5'd17, we: 1'b1});
    step();
    req_valid = 1'b0;
    tests++;
    if (obs0 !== {4'h7, 5'd17, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL zw_write got %h want %h", obs0, {4'h7, 5'd17, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
    end
    step();
    tests++;
    if (obs0_nw !== OBS_IDLE) begin
      fails++;
      $display("FAIL zw_idle got %h want %h", obs0_nw, OBS_IDLE);
    end
    repeat (4) step();
  endtask

  initial begin
    reset       = 1'b0;
    req_valid   = 1'b0;
    req_src     = '0;
    req_dst     = '0;
    req_is_load = 1'b0;
    test_reset();
    test_alu();
    test_load();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid_wait();
    test_zero_wait();
    repeat (3) step();
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL sb_drain got %0d pending want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
